// File: rtl/image_memory_if.sv
// image_memory_if: bus between the drawing-grid controller / display path
// and the image_memory pixel store.
//
// Signals (slave = image_memory, master = client):
//   write_addr   word address for writes, row-major (y*28+x)
//   read_addr    word address for reads, row-major
//   data_in      signed write data
//   write_enable single-cycle write qualifier
//   clear        single-cycle request to zero the whole array
//   data_out     registered signed read data (one cycle after read_addr)
//   clear_busy   high while the clear sweep runs
//   state_dbg    raw controller state (0 = IDLE, 1 = CLEARING)
//   pixel_count  number of nonzero words (IMAGE_MEMORY_PIXEL_COUNT_EN only)
//
// Handshake semantics: there is no valid/ready pair. write_enable and clear
// are qualifiers sampled on every rising clk edge with no back-pressure; a
// write offered while clear_busy=1 is dropped, not stalled, so a client that
// must not lose data waits for clear_busy=0 before asserting write_enable.
// Reads are always accepted and return one cycle later.
//
// Optional feature macro: IMAGE_MEMORY_PIXEL_COUNT_EN.
interface image_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic        [ADDR_WIDTH-1:0] write_addr;
  logic        [ADDR_WIDTH-1:0] read_addr;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         write_enable;
  logic                         clear;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic                         clear_busy;
  logic                         state_dbg;
`ifdef IMAGE_MEMORY_PIXEL_COUNT_EN
  logic        [9:0]            pixel_count;

  modport slave (
    input  write_addr, read_addr, data_in, write_enable, clear,
    output data_out, clear_busy, state_dbg, pixel_count
  );
  modport master (
    output write_addr, read_addr, data_in, write_enable, clear,
    input  data_out, clear_busy, state_dbg, pixel_count
  );
`else
  modport slave (
    input  write_addr, read_addr, data_in, write_enable, clear,
    output data_out, clear_busy, state_dbg
  );
  modport master (
    output write_addr, read_addr, data_in, write_enable, clear,
    input  data_out, clear_busy, state_dbg
  );
`endif
endinterface

// File: rtl/image_memory.sv
// image_memory: 28x28 pixel store, one signed word per pixel, with separate
// write and read addresses, a reset/explicit clear sweep and a registered
// one-cycle read port.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset; starts a clear sweep
//   bus     image_memory_if.slave (addresses, data, write_enable, clear,
//           data_out, clear_busy, state_dbg[, pixel_count])
//
// Optional feature macro: IMAGE_MEMORY_PIXEL_COUNT_EN adds pixel_count, the
// number of nonzero words, tracked by a DEPTH-bit nonzero bitmap.
module image_memory #(
  parameter int DEPTH      = 784,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           resetn,
  image_memory_if.slave  bus
);

  localparam int                    IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
  localparam logic [IDX_W-1:0]      LAST_PTR = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_CLEARING = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [IDX_W-1:0]             ptr_q, ptr_d;
  logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                         mem_we;
  logic [IDX_W-1:0]             mem_waddr;
  logic signed [DATA_WIDTH-1:0] mem_wdata;

  logic                         wr_in_range;
  logic                         rd_in_range;
  logic                         wr_accept;
  logic [IDX_W-1:0]             widx;
  logic [IDX_W-1:0]             ridx;

  assign wr_in_range = (bus.write_addr < DEPTH_A);
  assign rd_in_range = (bus.read_addr  < DEPTH_A);
  assign widx        = bus.write_addr[IDX_W-1:0];
  assign ridx        = bus.read_addr[IDX_W-1:0];
  assign wr_accept   = (state_q == ST_IDLE) && bus.write_enable && wr_in_range;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_we     = 1'b0;
    mem_waddr  = widx;
    mem_wdata  = bus.data_in;
    data_out_d = '0;
    case (state_q)
      ST_IDLE: begin
        mem_we = wr_accept;
        if (bus.clear) begin
          state_d = ST_CLEARING;
          ptr_d   = '0;
        end
        // Write-first: a read of the word being written sees the new data.
        if (rd_in_range) begin
          if (wr_accept && (widx == ridx)) data_out_d = bus.data_in;
          else                             data_out_d = mem_q[ridx];
        end
      end
      ST_CLEARING: begin
        // One word zeroed per cycle; reads return 0 until the sweep ends.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        if (bus.clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEARING;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_CLEARING;
      ptr_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Array has no reset; the sweep clears it. Gating on resetn drops a write
  // that lands on an edge while reset is still asserted.
  always_ff @(posedge clk) begin
    if (mem_we && resetn) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.clear_busy = (state_q == ST_CLEARING);
  assign bus.state_dbg  = state_q;

`ifdef IMAGE_MEMORY_PIXEL_COUNT_EN
  logic [DEPTH-1:0] nz_q, nz_d;
  logic [9:0]       count_q, count_d;
  logic             new_nz;

  assign new_nz = (bus.data_in != '0);

  always_comb begin
    nz_d    = nz_q;
    count_d = count_q;
    if (bus.clear) begin
      // The sweep will zero every word, so the count restarts immediately.
      nz_d    = '0;
      count_d = '0;
    end else if (wr_accept) begin
      nz_d[widx] = new_nz;
      count_d    = count_q + {9'b0, new_nz} - {9'b0, nz_q[widx]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      nz_q    <= '0;
      count_q <= '0;
    end else begin
      nz_q    <= nz_d;
      count_q <= count_d;
    end
  end

  assign bus.pixel_count = count_q;
`endif

endmodule

// File: tb/tb_image_memory.sv
// tb_image_memory: self-checking bench for image_memory. Reads are scored
// through an expected queue filled by the driver from a reference array.
module tb_image_memory;

  localparam int DEPTH = 784;
  localparam int DW    = 32;
  localparam int AW    = 16;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  image_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  image_memory #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  bit            model_clearing;
  int            n_checks;
  int            n_fail;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle: pushes the expected read result, updates the model.
  task automatic drive(input logic we, input logic [AW-1:0] waddr,
                       input logic [DW-1:0] wdata, input logic [AW-1:0] raddr);
    logic [DW-1:0] e;
    int wa;
    int ra;
    wa = int'(waddr);
    ra = int'(raddr);
    bus.write_enable = we;
    bus.write_addr   = waddr;
    bus.data_in      = wdata;
    bus.read_addr    = raddr;
    if (model_clearing)                            e = '0;
    else if (ra >= DEPTH)                          e = '0;
    else if (we && (wa == ra))                     e = wdata;
    else                                           e = model[ra];
    exp_q.push_back(e);
    if (!model_clearing && we && (wa < DEPTH)) model[wa] = wdata;
    step();
    bus.write_enable = 1'b0;
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Waits (bounded) for clear_busy to fall; returns edges counted.
  task automatic wait_sweep(input int start, output int cnt);
    cnt = start;
    while (bus.clear_busy === 1'b1 && cnt < 2000) begin
      step();
      cnt++;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) if (model[i] != '0) c++;
    return c;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt;
    logic [DW-1:0] e;
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.read_addr    = '0;
    bus.data_in      = '0;
    bus.clear        = 1'b0;
    model_clearing   = 1'b1;
    resetn           = 1'b0;
    repeat (3) step();
    n_checks++;
    if (bus.clear_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 1", bus.clear_busy);
    end
    n_checks++;
    if (bus.data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data_out: got %h expected 0", bus.data_out);
    end
    resetn = 1'b1;
    wait_sweep(0, cnt);
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL reset_sweep_len: got %0d cycles expected %0d", cnt, DEPTH);
    end
    model_zero();
    model_clearing = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, AW'(a));
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL reset_read addr %0d: got %h expected %h", a, bus.data_out, e);
      end
    end
  endtask

`ifdef IMAGE_MEMORY_PIXEL_COUNT_EN
  task automatic test_pixel_count();
    logic          t_we   [3] = '{1'b1, 1'b1, 1'b1};
    logic [AW-1:0] t_wa   [3] = '{16'd3, 16'd5, 16'd3};
    logic [DW-1:0] t_wd   [3] = '{32'd1, 32'd1, 32'd0};
    logic [AW-1:0] t_ra   [3] = '{16'd0, 16'd3, 16'd3};
    logic [9:0]    t_cnt  [3] = '{10'd1, 10'd2, 10'd1};
    logic [DW-1:0] e;
    int cnt;
    for (int i = 0; i < 3; i++) begin
      drive(t_we[i], t_wa[i], t_wd[i], t_ra[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL pc_read step %0d: got %h expected %h", i, bus.data_out, e);
      end
      n_checks++;
      if (bus.pixel_count !== t_cnt[i]) begin
        n_fail++;
        $display("FAIL pc_count step %0d: got %0d expected %0d", i, bus.pixel_count, t_cnt[i]);
      end
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.pixel_count !== 10'd0) begin
      n_fail++;
      $display("FAIL pc_async_reset: got %0d expected 0", bus.pixel_count);
    end
    model_clearing = 1'b1;
    repeat (2) step();
    resetn = 1'b1;
    wait_sweep(0, cnt);
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL pc_sweep_len: got %0d expected %0d", cnt, DEPTH);
    end
    model_zero();
    model_clearing = 1'b0;
  endtask
`endif

  task automatic test_write_read();
    logic          t_we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [AW-1:0] t_wa [4] = '{16'd406, 16'd0, 16'd0, 16'd0};
    logic [DW-1:0] t_wd [4] = '{32'd1, 32'd0, 32'd0, 32'd0};
    logic [AW-1:0] t_ra [4] = '{16'd0, 16'd406, 16'd405, 16'd407};
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(t_we[i], t_wa[i], t_wd[i], t_ra[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL write_read step %0d: got %h expected %h", i, bus.data_out, e);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic          t_we [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] t_wa [5] = '{16'd784, 16'd0, 16'd0, 16'hFFFF, 16'd0};
    logic [DW-1:0] t_wd [5] = '{32'h12345678, 32'd0, 32'd0, 32'd7, 32'd0};
    logic [AW-1:0] t_ra [5] = '{16'd0, 16'd784, 16'd0, 16'hFFFF, 16'd783};
    logic [DW-1:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(t_we[i], t_wa[i], t_wd[i], t_ra[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL out_of_range step %0d: got %h expected %h", i, bus.data_out, e);
      end
    end
  endtask

  task automatic test_collision();
    logic          t_we [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [AW-1:0] t_wa [6] = '{16'd27, 16'd0, 16'd28, 16'd0, 16'd27, 16'd0};
    logic [DW-1:0] t_wd [6] = '{32'hFFFFFFFB, 32'd0, 32'h80000000, 32'd0, 32'h7FFFFFFF, 32'd0};
    logic [AW-1:0] t_ra [6] = '{16'd27, 16'd27, 16'd28, 16'd28, 16'd26, 16'd27};
    logic [DW-1:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(t_we[i], t_wa[i], t_wd[i], t_ra[i]);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL collision step %0d: got %h expected %h", i, bus.data_out, e);
      end
    end
  endtask

  task automatic test_clear();
    logic [DW-1:0] e;
    int cnt;
    for (int a = 0; a < 10; a++) begin
      drive(1'b1, AW'(a), 32'd7, AW'(a));
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL clear_fill addr %0d: got %h expected %h", a, bus.data_out, e);
      end
    end
    // Clear edge itself is still an IDLE cycle, so its read is normal.
    bus.clear = 1'b1;
    drive(1'b0, '0, '0, 16'd0);
    bus.clear = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (bus.data_out !== e) begin
      n_fail++;
      $display("FAIL clear_edge_read: got %h expected %h", bus.data_out, e);
    end
    n_checks++;
    if (bus.clear_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_busy_rise: got %b expected 1", bus.clear_busy);
    end
`ifdef IMAGE_MEMORY_PIXEL_COUNT_EN
    n_checks++;
    if (bus.pixel_count !== 10'd0) begin
      n_fail++;
      $display("FAIL clear_count: got %0d expected 0", bus.pixel_count);
    end
`endif
    model_clearing = 1'b1;
    drive(1'b1, 16'd3, 32'd99, 16'd3);
    e = exp_q.pop_front();
    n_checks++;
    if (bus.data_out !== e) begin
      n_fail++;
      $display("FAIL clear_sweep_read: got %h expected %h", bus.data_out, e);
    end
    wait_sweep(1, cnt);
    n_checks++;
    if (cnt != DEPTH) begin
      n_fail++;
      $display("FAIL clear_sweep_len: got %0d expected %0d", cnt, DEPTH);
    end
    model_zero();
    model_clearing = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, AW'(a));
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL clear_read addr %0d: got %h expected %h", a, bus.data_out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic          we;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    logic [DW-1:0] e;
    for (int i = 0; i < 300; i++) begin
      we = 1'(($urandom_range(0, 3) != 0));
      wa = AW'($urandom_range(0, 799));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 799));
      wd = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      drive(we, wa, wd, ra);
      e = exp_q.pop_front();
      n_checks++;
      if (bus.data_out !== e) begin
        n_fail++;
        $display("FAIL b2b cycle %0d raddr %0d: got %h expected %h", i, ra, bus.data_out, e);
      end
`ifdef IMAGE_MEMORY_PIXEL_COUNT_EN
      n_checks++;
      if (int'(bus.pixel_count) != model_count()) begin
        n_fail++;
        $display("FAIL b2b_count cycle %0d: got %0d expected %0d", i, bus.pixel_count, model_count());
      end
`endif
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
`ifdef IMAGE_MEMORY_PIXEL_COUNT_EN
    test_pixel_count();
`endif
    test_write_read();
    test_out_of_range();
    test_collision();
    test_clear();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/image_memory.md
Name: image_memory

Overview:
- Dual-address pixel store for the 28x28 MNIST drawing grid: one 32-bit signed word per pixel.
- Written by the cursor/draw logic through write_addr; read by the VGA redraw sweep and downstream NN logic through read_addr.
- Provides power-on/reset clear and an explicit clear request.
- Sits between the drawing-grid controller and the display/inference path.

Parameters:
- DEPTH, 784, number of words (GRID_SIZE*GRID_SIZE).
- DATA_WIDTH, 32, word width, signed.
- ADDR_WIDTH, 16, width of both address ports.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- write_addr  in  ADDR_WIDTH  write word address, row-major (y*28+x).
- read_addr  in  ADDR_WIDTH  read word address, row-major.
- data_in  in  DATA_WIDTH signed  write data.
- write_enable  in  1  write strobe, sampled on clk rise.
- clear  in  1  synchronous request to zero the whole array.
- data_out  out  DATA_WIDTH signed  registered read data.
- clear_busy  out  1  high while clear sweep runs.

Behaviour:
- Reset, asynchronous on resetn low:
  - data_out=0.
  - clear_busy=1.
  - Internal clear pointer=0, state=CLEARING.
  - Array contents are not touched asynchronously.
- After resetn deasserts, the CLEARING state writes 0 to address ptr each cycle, ptr 0..DEPTH-1.
  - After writing DEPTH-1: state=IDLE and clear_busy=0 on the next edge.
  - Total clear time is DEPTH cycles.
- States:
  - IDLE: normal operation.
  - CLEARING: sweep in progress.
  - clear=1 in IDLE -> CLEARING with ptr=0 and clear_busy=1 on the next edge.
  - clear=1 during CLEARING restarts the sweep at ptr=0.
- Write:
  - In IDLE, with write_enable=1 and write_addr<DEPTH, mem[write_addr]<=data_in on the clk edge.
  - Writes with write_addr>=DEPTH are silently dropped.
  - All user writes are ignored during CLEARING.
- Read:
  - Read latency is 1 cycle: data_out <= mem[read_addr] on each clk edge.
  - Out of range (read_addr>=DEPTH) -> data_out <= 0.
  - During CLEARING, data_out <= 0 regardless of address.
- Same-address collision:
  - Read and write to the same in-range address in the same IDLE cycle use write-first behaviour.
  - data_out takes the new data_in on that edge.
- Reset mid-sweep or mid-write:
  - Aborts the operation and restarts the sweep from 0.
  - A write on the edge coinciding with resetn low is lost.
- No arithmetic on data; full 32-bit signed values are stored verbatim, including negative values.

Optional Feature:
- Macro IMAGE_MEMORY_PIXEL_COUNT_EN.
- When defined, add output pixel_count, 10 bits: the number of words currently nonzero.
  - Maintained by a DEPTH-bit nonzero bitmap.
  - On an accepted write, the count is adjusted by (new!=0)-(old bit).
  - Cleared to 0 on reset, and at the start of each clear request.
  - The count updates on the same edge as the write.
- When not defined, the port and bitmap do not exist; all other behaviour is identical.

Test Plan:
- Reset, then wait: resetn low 3 cycles then high -> clear_busy=1 for exactly 784 cycles then 0; a read of addr 0..783 returns 0 one cycle after the address.
- Write then read: after clear, write addr 406 (y=14,x=14) data 1; next cycle read_addr=406 -> data_out=1 one cycle later; addr 405 reads 0.
- Out-of-range: write addr 784 data 0x12345678; read addr 784 -> 0; addr 0 still reads 0.
- Collision and negative data: write_enable=1, write_addr=read_addr=27, data_in=-5 -> data_out=-5 (0xFFFFFFFB) after that edge.
- Clear mid-use: fill addrs 0..9 with 7, assert clear 1 cycle -> clear_busy=1 next edge; a write attempted during the sweep is dropped; all addrs read 0 after 784 cycles.
- With IMAGE_MEMORY_PIXEL_COUNT_EN:
  - Write 1 to addrs 3 and 5 -> pixel_count=2.
  - Rewrite addr 3 with 0 -> pixel_count=1.
  - Assert resetn low -> pixel_count=0 immediately.
